// File: rtl/periph_pkg.sv
// rtl/periph_pkg.sv - shared constants and types for the memory-mapped peripheral block
//
// Contents:
//   BASE_ADDR_DEF       default base of the 32-byte register window
//   OFS_TH..OFS_SYSTICK word offsets (Addr[4:2]) of the registers
//   TCON_EN/IE/ST       bit positions inside TCON
//   timer_we_t          per-register write strobes handed from the decoder to the timer
//   addr_hit()          window match on Addr[31:5]
package periph_pkg;

    localparam logic [31:0] BASE_ADDR_DEF = 32'h4000_0000;

    localparam logic [2:0] OFS_TH      = 3'd0;
    localparam logic [2:0] OFS_TL      = 3'd1;
    localparam logic [2:0] OFS_TCON    = 3'd2;
    localparam logic [2:0] OFS_LED     = 3'd3;
    localparam logic [2:0] OFS_SW      = 3'd4;
    localparam logic [2:0] OFS_DIGI    = 3'd5;
    localparam logic [2:0] OFS_SYSTICK = 3'd6;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_ST = 2;

    typedef struct packed {
        logic th;
        logic tl;
        logic tcon;
    } timer_we_t;

    function automatic logic addr_hit(input logic [31:0] addr, input logic [31:0] base);
        return addr[31:5] == base[31:5];
    endfunction

endpackage

// File: rtl/periph_timer.sv
// rtl/periph_timer.sv - reloading 32-bit timer with prescaler and level interrupt
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-high reset
//   we_i       write strobes for TH / TL / TCON (already qualified by address hit)
//   wdata_i    store data
//   th_o       TH reload value
//   tl_o       TL counter value
//   tcon_o     {ST, IE, EN}
//   irq_o      IE & ST
module periph_timer
    import periph_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  timer_we_t   we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] th_o,
    output logic [31:0] tl_o,
    output logic [2:0]  tcon_o,
    output logic        irq_o
);

    localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;
    logic [15:0] pre_q, pre_d;
    logic        tick;
    logic        ovf;

    always_comb begin
        tick = tcon_q[TCON_EN] && (pre_q == PRE_LAST);
        // Overflow only raises ST when interrupts are enabled at that edge.
        ovf  = tick && (tl_q == 32'hFFFF_FFFF) && tcon_q[TCON_IE];

        pre_d = pre_q;
        if (we_i.tcon) begin
            pre_d = 16'd0;
        end else if (tcon_q[TCON_EN]) begin
            pre_d = tick ? 16'd0 : pre_q + 16'd1;
        end

        th_d = we_i.th ? wdata_i : th_q;

        // A CPU store to TL takes priority over increment/reload.
        tl_d = tl_q;
        if (we_i.tl) begin
            tl_d = wdata_i;
        end else if (tick) begin
            tl_d = (tl_q == 32'hFFFF_FFFF) ? th_q : tl_q + 32'd1;
        end

        // ST is OR-ed with the overflow even when software writes TCON on the
        // same edge, so an interrupt can never be dropped by a racing store.
        tcon_d = tcon_q;
        if (we_i.tcon) begin
            tcon_d = wdata_i[2:0];
        end
        tcon_d[TCON_ST] = tcon_d[TCON_ST] | ovf;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th_q   <= '0;
            tl_q   <= '0;
            tcon_q <= '0;
            pre_q  <= '0;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            tcon_q <= tcon_d;
            pre_q  <= pre_d;
        end
    end

    assign th_o   = th_q;
    assign tl_o   = tl_q;
    assign tcon_o = tcon_q;
    assign irq_o  = tcon_q[TCON_IE] & tcon_q[TCON_ST];

endmodule

// File: rtl/periph_bus.sv
// rtl/periph_bus.sv - memory-mapped peripheral block: decode, read mux, LED/DIGI/SYSTICK, switch sync
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-high reset
//   Addr       byte address from the ALU (Addr[1:0] ignored)
//   MemRead    load strobe
//   MemWrite   store strobe
//   WriteData  store data
//   ReadData   combinational load data, 0 on miss / no load
//   IRQ        timer interrupt (level)
//   LED        LED register
//   Switch     asynchronous board switches
//   Digi       7-seg register ([11:8] digit enable, [7:0] segments)
module periph_bus
    import periph_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF,
    parameter int          LED_W     = 8,
    parameter int          SW_W      = 8,
    parameter int          DIGI_W    = 12,
    parameter int          PRESCALE  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       Addr,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [31:0]       WriteData,
    output logic [31:0]       ReadData,
    output logic              IRQ,
    output logic [LED_W-1:0]  LED,
    input  logic [SW_W-1:0]   Switch,
    output logic [DIGI_W-1:0] Digi
);

    logic              hit;
    logic [2:0]        ofs;
    logic              wr_hit;
    timer_we_t         timer_we;
    logic              unused_addr_lsb;

    logic [LED_W-1:0]  led_q, led_d;
    logic [DIGI_W-1:0] digi_q, digi_d;
    logic [31:0]       systick_q, systick_d;
    logic [SW_W-1:0]   sw_meta_q, sw_sync_q;

    logic [31:0]       th;
    logic [31:0]       tl;
    logic [2:0]        tcon;

    assign hit             = addr_hit(Addr, BASE_ADDR);
    assign ofs             = Addr[4:2];
    assign wr_hit          = MemWrite && hit;
    assign unused_addr_lsb = ^Addr[1:0];

    always_comb begin
        timer_we.th   = wr_hit && (ofs == OFS_TH);
        timer_we.tl   = wr_hit && (ofs == OFS_TL);
        timer_we.tcon = wr_hit && (ofs == OFS_TCON);

        led_d     = (wr_hit && (ofs == OFS_LED))  ? WriteData[LED_W-1:0]  : led_q;
        digi_d    = (wr_hit && (ofs == OFS_DIGI)) ? WriteData[DIGI_W-1:0] : digi_q;
        systick_d = systick_q + 32'd1;
    end

    periph_timer #(
        .PRESCALE (PRESCALE)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .we_i    (timer_we),
        .wdata_i (WriteData),
        .th_o    (th),
        .tl_o    (tl),
        .tcon_o  (tcon),
        .irq_o   (IRQ)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q     <= '0;
            digi_q    <= '0;
            systick_q <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            led_q     <= led_d;
            digi_q    <= digi_d;
            systick_q <= systick_d;
            sw_meta_q <= Switch;
            sw_sync_q <= sw_meta_q;
        end
    end

    // Loads are side-effect free; offset 7 and misses return zero.
    always_comb begin
        ReadData = '0;
        if (MemRead && hit) begin
            case (ofs)
                OFS_TH:      ReadData = th;
                OFS_TL:      ReadData = tl;
                OFS_TCON:    ReadData = {29'd0, tcon};
                OFS_LED:     ReadData = 32'(led_q);
                OFS_SW:      ReadData = 32'(sw_sync_q);
                OFS_DIGI:    ReadData = 32'(digi_q);
                OFS_SYSTICK: ReadData = systick_q;
                default:     ReadData = '0;
            endcase
        end
    end

    assign LED  = led_q;
    assign Digi = digi_q;

endmodule
